// File: rtl/comp_sign_lt_serial_if.sv
// Operand and result handshake bundle for the bit-serial signed less-than unit.
// The requester drives operands and result acceptance; the comparator drives
// the ready/valid/result/busy status.
interface comp_sign_lt_serial_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic             res_lt;
  logic             busy;

  modport master (
    output start_valid,
    output a,
    output b,
    output res_ready,
    input  start_ready,
    input  res_valid,
    input  res_lt,
    input  busy
  );

  modport slave (
    input  start_valid,
    input  a,
    input  b,
    input  res_ready,
    output start_ready,
    output res_valid,
    output res_lt,
    output busy
  );
endinterface

// File: rtl/comp_sign_lt_serial.sv
// Bit-serial two's-complement less-than comparator.
// Operands are walked LSB first, one bit per clock. The decision flag keeps the
// verdict of the most significant differing bit seen so far, so the last
// differing bit wins. At the sign position the sense of the decision inverts:
// a 1 in a there means a is negative while b is not.
module comp_sign_lt_serial #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  comp_sign_lt_serial_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_lt;
  logic             r_start_ready;
  logic             r_res_valid;
  logic             r_res_lt;
  logic             r_busy;

  logic w_ai;
  logic w_bi;
  logic w_last;
  logic w_lt_step;

  // Per-bit decision: equal bits keep the verdict, a differing magnitude bit
  // takes b's bit, a differing sign bit takes a's bit.
  always_comb begin
    w_ai      = r_sa[0];
    w_bi      = r_sb[0];
    w_last    = (r_cnt == LAST_IDX);
    w_lt_step = r_lt;
    if (w_ai ^ w_bi) begin
      w_lt_step = w_last ? w_ai : w_bi;
    end
  end

  // Control FSM and datapath; handshake outputs are registered alongside the
  // state so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sa          <= '0;
      r_sb          <= '0;
      r_cnt         <= '0;
      r_lt          <= 1'b0;
      r_start_ready <= 1'b1;
      r_res_valid   <= 1'b0;
      r_res_lt      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_valid) begin
            r_sa          <= bus.a;
            r_sb          <= bus.b;
            r_cnt         <= '0;
            r_lt          <= 1'b0;
            r_state       <= S_RUN;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_RUN: begin
          r_lt <= w_lt_step;
          r_sa <= r_sa >> 1;
          r_sb <= r_sb >> 1;
          if (w_last) begin
            // Counter parks on the last index so it can never wrap back.
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_res_lt    <= w_lt_step;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_state       <= S_IDLE;
            r_res_valid   <= 1'b0;
            r_res_lt      <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_res_valid   <= 1'b0;
          r_res_lt      <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_lt      = r_res_lt;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_comp_sign_lt_serial.sv
// Directed plus random bench for the bit-serial signed comparator at WIDTH 32,
// 8 and 2, with a scoreboard of expected verdicts per instance.
module tb_comp_sign_lt_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comp_sign_lt_serial_if #(.WIDTH(32)) bus32 ();
  comp_sign_lt_serial_if #(.WIDTH(8))  bus8 ();
  comp_sign_lt_serial_if #(.WIDTH(2))  bus2 ();

  comp_sign_lt_serial #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  comp_sign_lt_serial #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  comp_sign_lt_serial #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2.slave));

  int   checks = 0;
  int   errors = 0;
  logic q32[$];
  logic q8[$];
  logic q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for ready, perform the start handshake, record the expected verdict.
  // Returns at the falling edge after the handshake; start_valid is left at
  // 'pulse' and the operand lines are scrambled to prove they are not resampled.
  task automatic start32(input logic [31:0] a, input logic [31:0] b, input bit pulse);
    int n = 0;
    while (!bus32.start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("start_ready_wait", 32'(bus32.start_ready), 32'd1);
    bus32.a = a;
    bus32.b = b;
    bus32.start_valid = 1'b1;
    @(posedge clk);
    q32.push_back($signed(a) < $signed(b));
    @(negedge clk);
    bus32.start_valid = pulse;
    bus32.a = ~a;
    bus32.b = b ^ 32'h5A5A_5A5A;
  endtask

  // Entered at the falling edge after the start handshake. Checks latency,
  // idle-result gating, back-pressure stability, the verdict and the return
  // to IDLE.
  task automatic finish32(input int hold, input bit chk_lat);
    int   lat = 0;
    logic e;
    while (!bus32.res_valid && lat < 200) begin
      chk("res_lt_gated", 32'(bus32.res_lt), 32'd0);
      chk("start_ready_busy", 32'(bus32.start_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("timeout32", 32'(lat < 200), 32'd1);
    if (chk_lat) chk("latency32", 32'(lat), 32'd32);
    e = (q32.size() > 0) ? q32[0] : 1'bx;
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(bus32.res_valid), 32'd1);
      chk("hold_lt", 32'(bus32.res_lt), 32'(e));
      @(negedge clk);
    end
    bus32.start_valid = 1'b0;
    if (q32.size() > 0) void'(q32.pop_front());
    chk("res_lt32", 32'(bus32.res_lt), 32'(e));
    bus32.res_ready = 1'b1;
    @(negedge clk);
    bus32.res_ready = 1'b0;
    chk("post_start_ready", 32'(bus32.start_ready), 32'd1);
    chk("post_res_valid", 32'(bus32.res_valid), 32'd0);
    chk("post_busy", 32'(bus32.busy), 32'd0);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input int hold, input bit pulse);
    start32(a, b, pulse);
    finish32(hold, 1'b1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int   n = 0;
    logic e;
    while (!bus8.start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus8.a = a;
    bus8.b = b;
    bus8.start_valid = 1'b1;
    @(posedge clk);
    q8.push_back($signed(a) < $signed(b));
    @(negedge clk);
    bus8.start_valid = 1'b0;
    n = 0;
    while (!bus8.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency8", 32'(n), 32'd8);
    e = q8.pop_front();
    chk("res_lt8", 32'(bus8.res_lt), 32'(e));
    bus8.res_ready = 1'b1;
    @(negedge clk);
    bus8.res_ready = 1'b0;
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    int   n = 0;
    logic e;
    while (!bus2.start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus2.a = a;
    bus2.b = b;
    bus2.start_valid = 1'b1;
    @(posedge clk);
    q2.push_back($signed(a) < $signed(b));
    @(negedge clk);
    bus2.start_valid = 1'b0;
    n = 0;
    while (!bus2.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency2", 32'(n), 32'd2);
    e = q2.pop_front();
    chk("res_lt2", 32'(bus2.res_lt), 32'(e));
    bus2.res_ready = 1'b1;
    @(negedge clk);
    bus2.res_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ext [4];

    bus32.start_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.res_ready = 1'b0;
    bus8.start_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.res_ready  = 1'b0;
    bus2.start_valid  = 1'b0; bus2.a  = '0; bus2.b  = '0; bus2.res_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_start_ready", 32'(bus32.start_ready), 32'd1);
    chk("rst_res_valid", 32'(bus32.res_valid), 32'd0);
    chk("rst_res_lt", 32'(bus32.res_lt), 32'd0);
    chk("rst_busy", 32'(bus32.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Case A, B, C
    op32(32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0);
    op32(32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);
    op32(32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b0);
    op32(32'h1234_5678, 32'h1234_5678, 0, 1'b0);
    op32(32'h8000_0000, 32'h8000_0001, 0, 1'b0);
    op32(32'h0000_0002, 32'h0000_0001, 0, 1'b0);

    // Case D: back-pressure with start_valid held during RUN/DONE
    op32(32'hFFFF_FFFE, 32'hFFFF_FFFF, 5, 1'b1);

    // Case E: reset at bit 10 with start_valid held high
    start32(32'h0000_0005, 32'hFFFF_FFF0, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    bus32.a = 32'hFFFF_FFF0;
    bus32.b = 32'h0000_0005;
    @(negedge clk);
    chk("mid_rst_start_ready", 32'(bus32.start_ready), 32'd1);
    chk("mid_rst_res_valid", 32'(bus32.res_valid), 32'd0);
    chk("mid_rst_res_lt", 32'(bus32.res_lt), 32'd0);
    chk("mid_rst_busy", 32'(bus32.busy), 32'd0);
    q32.delete();
    rst = 1'b0;
    @(posedge clk);
    q32.push_back(1'b1);
    @(negedge clk);
    bus32.start_valid = 1'b0;
    chk("restart_busy", 32'(bus32.busy), 32'd1);
    finish32(0, 1'b1);

    // Case F: extremes, all sign combinations, random back-pressure
    ext[0] = 32'h8000_0000; ext[1] = 32'h7FFF_FFFF; ext[2] = 32'h0000_0000; ext[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        op32(ext[i], ext[j], 0, 1'b0);
    for (int i = 0; i < 1200; i++) begin
      ra = $urandom;
      rb = (i % 8 == 0) ? ra ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
      ra[31] = i[0];
      rb[31] = i[1];
      op32(ra, rb, $urandom_range(0, 3), 1'b0);
    end

    // Narrow widths
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        op2(2'(i), 2'(j));
    op8(8'h80, 8'h7F);
    op8(8'h7F, 8'h80);
    op8(8'hFF, 8'h00);
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      op8(ra[7:0], rb[7:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
